// File: rtl/err_conv_mon_pkg.sv
// err_conv_mon_pkg
//   Shared definitions for the error convergence monitor family: error and
//   magnitude widths, FSM state encodings and the accumulator width
//   derivation. Later monitor blocks import the same package so that the
//   state encodings stay identical across the family.
package err_conv_mon_pkg;

  // Filter error width and its magnitude width. -512 maps to 512, so the
  // magnitude needs one more bit than the error.
  localparam int E_W   = 10;
  localparam int ABS_W = 11;

  // Window FSM state encodings
  typedef logic [1:0] state_t;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;

  // Accumulator width for a window of 2^win_log2 magnitudes. The sum can
  // reach 512 * 2^win_log2, which always fits in ABS_W + win_log2 bits.
  function automatic int acc_width(input int win_log2);
    return ABS_W + win_log2;
  endfunction

endpackage

// File: rtl/err_conv_mon_abs_e.sv
// err_conv_mon_abs_e
//   Combinational magnitude of a 10-bit two's complement error.
//   Ports:
//     e    in  10  filter error, two's complement
//     mag  out 11  |e| as unsigned; e = -512 gives 512 (no wrap)
module err_conv_mon_abs_e
  import err_conv_mon_pkg::*;
(
  input  logic [E_W-1:0]   e,
  output logic [ABS_W-1:0] mag
);

  logic [ABS_W-1:0] ext_s;

  // Sign-extend one bit first so negating the most negative value fits
  always_comb begin
    ext_s = {e[E_W-1], e};
    if (e[E_W-1]) begin
      mag = (~ext_s) + {{(ABS_W-1){1'b0}}, 1'b1};
    end else begin
      mag = ext_s;
    end
  end

endmodule

// File: rtl/err_conv_mon.sv
// err_conv_mon
//   Convergence monitor downstream of the adaptive filter. Sums |e| over
//   windows of 2^WIN_LOG2 valid samples, reports each window sum with a
//   one-cycle win_done pulse, and raises conv once HOLD consecutive windows
//   have a sum strictly below thr.
//
//   Parameters:
//     WIN_LOG2  log2 of window length in samples
//     HOLD      consecutive below-threshold windows needed for conv (1..15)
//     ACC_W     derived accumulator/sum width (11 + WIN_LOG2)
//
//   Ports:
//     clk       in   1      clock, all state on posedge
//     r         in   1      asynchronous active-high reset
//     clr       in   1      synchronous clear of window, hold count and conv
//     e_vld     in   1      e valid this cycle
//     e         in   10     filter error, two's complement
//     thr       in   ACC_W  unsigned window-sum threshold, used at evaluation
//     win_sum   out  ACC_W  sum of |e| over the last completed window
//     win_done  out  1      one-cycle pulse when win_sum updates
//     conv      out  1      converged flag
//     hold_cnt  out  4      consecutive below-threshold windows, saturates at HOLD
//     win_peak  out  11     (ERR_CONV_PEAK_EN only) max |e| of last completed window
//
//   Build option: define ERR_CONV_PEAK_EN to add the win_peak reporting
//   output. It does not influence conv.
module err_conv_mon
  import err_conv_mon_pkg::*;
#(
  parameter  int WIN_LOG2 = 3,
  parameter  int HOLD     = 2,
  localparam int ACC_W    = acc_width(WIN_LOG2)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             clr,
  input  logic             e_vld,
  input  logic [E_W-1:0]   e,
  input  logic [ACC_W-1:0] thr,
  output logic [ACC_W-1:0] win_sum,
  output logic             win_done,
  output logic             conv,
  output logic [3:0]       hold_cnt
`ifdef ERR_CONV_PEAK_EN
  ,
  output logic [ABS_W-1:0] win_peak
`endif
);

  localparam logic [WIN_LOG2-1:0] SMP_LAST = {WIN_LOG2{1'b1}};
  localparam logic [WIN_LOG2-1:0] SMP_ONE  = WIN_LOG2'(1);
  localparam logic [3:0]          HOLD_V   = 4'(HOLD);

  state_t              state_r;
  logic [WIN_LOG2-1:0] smp_cnt_r;
  logic [ACC_W-1:0]    acc_r;
  logic [ACC_W-1:0]    win_sum_r;
  logic                win_done_r;
  logic                conv_r;
  logic [3:0]          hold_cnt_r;

  logic [ABS_W-1:0]    abs_s;
  logic [ACC_W-1:0]    sum_s;
  logic                last_s;
  logic                legal_s;
  logic                take_s;
  logic                below_s;
  logic [4:0]          hold_inc_s;
  logic [3:0]          hold_nxt_s;
  logic                conv_nxt_s;

  err_conv_mon_abs_e u_abs_e (
    .e   (e),
    .mag (abs_s)
  );

  // Datapath helpers: running sum, window-end detect, threshold compare
  always_comb begin
    sum_s  = acc_r + ACC_W'(abs_s);
    last_s = (smp_cnt_r == SMP_LAST);
    // Strict compare: a sum equal to thr does not count as converged
    below_s = (win_sum_r < thr);
    case (state_r)
      S_IDLE, S_ACC, S_EVAL: legal_s = 1'b1;
      default:               legal_s = 1'b0;
    endcase
    take_s = e_vld & legal_s;
  end

  // Saturating hold increment; 5 bits so HOLD = 15 cannot wrap to 0
  always_comb begin
    hold_inc_s = {1'b0, hold_cnt_r} + 5'd1;
    if (hold_inc_s >= {1'b0, HOLD_V}) begin
      hold_nxt_s = HOLD_V;
      conv_nxt_s = 1'b1;
    end else begin
      hold_nxt_s = hold_inc_s[3:0];
      conv_nxt_s = 1'b0;
    end
  end

  // Window FSM, sample counter, accumulator, hold counter and conv flag
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_r    <= S_IDLE;
      smp_cnt_r  <= {WIN_LOG2{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      win_sum_r  <= {ACC_W{1'b0}};
      win_done_r <= 1'b0;
      conv_r     <= 1'b0;
      hold_cnt_r <= 4'd0;
    end else if (clr) begin
      // win_sum keeps the last reported value; a pending evaluation is dropped
      state_r    <= S_IDLE;
      smp_cnt_r  <= {WIN_LOG2{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      win_sum_r  <= win_sum_r;
      win_done_r <= 1'b0;
      conv_r     <= 1'b0;
      hold_cnt_r <= 4'd0;
    end else begin
      win_done_r <= 1'b0;

      // Evaluation happens in the cycle after the last sample, against the
      // thr value present in that cycle
      if (state_r == S_EVAL) begin
        if (below_s) begin
          hold_cnt_r <= hold_nxt_s;
          conv_r     <= conv_nxt_s;
        end else begin
          hold_cnt_r <= 4'd0;
          conv_r     <= 1'b0;
        end
      end else begin
        hold_cnt_r <= hold_cnt_r;
        conv_r     <= conv_r;
      end

      // A sample arriving during S_EVAL is sample 0 of the next window
      case (state_r)
        S_IDLE, S_ACC, S_EVAL: begin
          if (take_s) begin
            if (last_s) begin
              win_sum_r  <= sum_s;
              acc_r      <= {ACC_W{1'b0}};
              smp_cnt_r  <= {WIN_LOG2{1'b0}};
              win_done_r <= 1'b1;
              state_r    <= S_EVAL;
            end else begin
              acc_r      <= sum_s;
              smp_cnt_r  <= smp_cnt_r + SMP_ONE;
              state_r    <= S_ACC;
            end
          end else if (state_r == S_EVAL) begin
            state_r <= S_ACC;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          smp_cnt_r <= {WIN_LOG2{1'b0}};
          acc_r     <= {ACC_W{1'b0}};
        end
      endcase
    end
  end

  assign win_sum  = win_sum_r;
  assign win_done = win_done_r;
  assign conv     = conv_r;
  assign hold_cnt = hold_cnt_r;

`ifdef ERR_CONV_PEAK_EN
  logic [ABS_W-1:0] peak_acc_r;
  logic [ABS_W-1:0] win_peak_r;
  logic [ABS_W-1:0] peak_max_s;

  // Running maximum including the current sample
  always_comb begin
    if (abs_s > peak_acc_r) begin
      peak_max_s = abs_s;
    end else begin
      peak_max_s = peak_acc_r;
    end
  end

  // Peak tracker, published in the same cycle as win_sum
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      peak_acc_r <= {ABS_W{1'b0}};
      win_peak_r <= {ABS_W{1'b0}};
    end else if (clr) begin
      peak_acc_r <= {ABS_W{1'b0}};
      win_peak_r <= {ABS_W{1'b0}};
    end else if (take_s && last_s) begin
      win_peak_r <= peak_max_s;
      peak_acc_r <= {ABS_W{1'b0}};
    end else if (take_s) begin
      peak_acc_r <= peak_max_s;
    end else if (!legal_s) begin
      peak_acc_r <= {ABS_W{1'b0}};
    end else begin
      peak_acc_r <= peak_acc_r;
    end
  end

  assign win_peak = win_peak_r;
`endif

endmodule

// File: tb/tb_err_conv_mon.sv
// tb_err_conv_mon
//   Directed self-checking bench for err_conv_mon (WIN_LOG2=3, HOLD=2).
//   Inputs change 1 time unit after the rising edge; outputs are read at
//   the same point, well away from the next edge.
module tb_err_conv_mon;

  logic        clk;
  logic        r;
  logic        clr;
  logic        e_vld;
  logic [9:0]  e;
  logic [13:0] thr;
  logic [13:0] win_sum;
  logic        win_done;
  logic        conv;
  logic [3:0]  hold_cnt;
`ifdef ERR_CONV_PEAK_EN
  logic [10:0] win_peak;
`endif

  int n_checks;
  int n_fail;

  err_conv_mon #(.WIN_LOG2(3), .HOLD(2)) dut (
    .clk      (clk),
    .r        (r),
    .clr      (clr),
    .e_vld    (e_vld),
    .e        (e),
    .thr      (thr),
    .win_sum  (win_sum),
    .win_done (win_done),
    .conv     (conv),
    .hold_cnt (hold_cnt)
`ifdef ERR_CONV_PEAK_EN
    ,
    .win_peak (win_peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n consecutive valid samples of value v; returns 1 unit after the last edge
  task automatic send(input logic [9:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      e_vld = 1'b1;
      e     = v;
      @(posedge clk);
      #1;
    end
    e_vld = 1'b0;
  endtask

  task automatic window(input logic [9:0] v, input logic [13:0] t);
    thr = t;
    send(v, 8);
  endtask

  task automatic test_reset;
    r = 1'b1; clr = 1'b0; e_vld = 1'b0; e = 10'd0; thr = 14'd0;
    idle(3);
    r = 1'b0;
    idle(20);
    n_checks++; if (win_sum !== 14'd0) begin n_fail++; $display("FAIL reset_win_sum: got %0d expected 0", win_sum); end
    n_checks++; if (win_done !== 1'b0) begin n_fail++; $display("FAIL reset_win_done: got %0b expected 0", win_done); end
    n_checks++; if (conv !== 1'b0) begin n_fail++; $display("FAIL reset_conv: got %0b expected 0", conv); end
    n_checks++; if (hold_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_hold_cnt: got %0d expected 0", hold_cnt); end
    n_checks++; if (dut.state_r !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dut.state_r); end
  endtask

  task automatic test_below_thr;
    window(10'd4, 14'd40);
    n_checks++; if (win_done !== 1'b1) begin n_fail++; $display("FAIL below1_done: got %0b expected 1", win_done); end
    n_checks++; if (win_sum !== 14'd32) begin n_fail++; $display("FAIL below1_sum: got %0d expected 32", win_sum); end
    idle(1);
    n_checks++; if (win_done !== 1'b0) begin n_fail++; $display("FAIL below1_done_pulse: got %0b expected 0", win_done); end
    n_checks++; if (hold_cnt !== 4'd1) begin n_fail++; $display("FAIL below1_hold: got %0d expected 1", hold_cnt); end
    n_checks++; if (conv !== 1'b0) begin n_fail++; $display("FAIL below1_conv: got %0b expected 0", conv); end
    window(10'd4, 14'd40);
    idle(1);
    n_checks++; if (hold_cnt !== 4'd2) begin n_fail++; $display("FAIL below2_hold: got %0d expected 2", hold_cnt); end
    n_checks++; if (conv !== 1'b1) begin n_fail++; $display("FAIL below2_conv: got %0b expected 1", conv); end
    window(10'd4, 14'd40);
    idle(1);
    n_checks++; if (hold_cnt !== 4'd2) begin n_fail++; $display("FAIL below3_hold_sat: got %0d expected 2", hold_cnt); end
    n_checks++; if (conv !== 1'b1) begin n_fail++; $display("FAIL below3_conv: got %0b expected 1", conv); end
  endtask

  task automatic test_above_thr;
    window(10'h200, 14'd100);
    n_checks++; if (win_sum !== 14'd4096) begin n_fail++; $display("FAIL above_sum: got %0d expected 4096", win_sum); end
    idle(1);
    n_checks++; if (hold_cnt !== 4'd0) begin n_fail++; $display("FAIL above_hold: got %0d expected 0", hold_cnt); end
    n_checks++; if (conv !== 1'b0) begin n_fail++; $display("FAIL above_conv: got %0b expected 0", conv); end
  endtask

  task automatic test_strict;
    window(10'd4, 14'd40);
    idle(1);
    window(10'd4, 14'd40);
    idle(1);
    n_checks++; if (conv !== 1'b1) begin n_fail++; $display("FAIL strict_pre_conv: got %0b expected 1", conv); end
    window(10'h3FB, 14'd40);
    n_checks++; if (win_sum !== 14'd40) begin n_fail++; $display("FAIL strict_sum: got %0d expected 40", win_sum); end
    idle(1);
    n_checks++; if (conv !== 1'b0) begin n_fail++; $display("FAIL strict_conv: got %0b expected 0", conv); end
    n_checks++; if (hold_cnt !== 4'd0) begin n_fail++; $display("FAIL strict_hold: got %0d expected 0", hold_cnt); end
  endtask

  task automatic test_back_to_back;
    thr = 14'd40;
    for (int i = 0; i < 16; i++) begin
      e_vld = 1'b1;
      e     = 10'd1;
      @(posedge clk);
      #1;
      if (i == 7) begin
        n_checks++; if (win_done !== 1'b1) begin n_fail++; $display("FAIL b2b_w1_done: got %0b expected 1", win_done); end
        n_checks++; if (win_sum !== 14'd8) begin n_fail++; $display("FAIL b2b_w1_sum: got %0d expected 8", win_sum); end
      end
      if (i == 8) begin
        n_checks++; if (win_done !== 1'b0) begin n_fail++; $display("FAIL b2b_eval_done: got %0b expected 0", win_done); end
        n_checks++; if (hold_cnt !== 4'd1) begin n_fail++; $display("FAIL b2b_w1_hold: got %0d expected 1", hold_cnt); end
      end
      if (i == 15) begin
        n_checks++; if (win_done !== 1'b1) begin n_fail++; $display("FAIL b2b_w2_done: got %0b expected 1", win_done); end
        n_checks++; if (win_sum !== 14'd8) begin n_fail++; $display("FAIL b2b_w2_sum: got %0d expected 8", win_sum); end
      end
    end
    e_vld = 1'b0;
    idle(1);
    n_checks++; if (hold_cnt !== 4'd2) begin n_fail++; $display("FAIL b2b_w2_hold: got %0d expected 2", hold_cnt); end
    n_checks++; if (conv !== 1'b1) begin n_fail++; $display("FAIL b2b_w2_conv: got %0b expected 1", conv); end
  endtask

  task automatic test_thr_change;
    // Generous thr early, zero at evaluation: only the evaluation value counts
    thr = 14'd40;
    send(10'd4, 4);
    thr = 14'd0;
    send(10'd4, 4);
    idle(1);
    n_checks++; if (hold_cnt !== 4'd0) begin n_fail++; $display("FAIL thr_late_low_hold: got %0d expected 0", hold_cnt); end
    n_checks++; if (conv !== 1'b0) begin n_fail++; $display("FAIL thr_late_low_conv: got %0b expected 0", conv); end
    send(10'd4, 4);
    thr = 14'd40;
    send(10'd4, 4);
    idle(1);
    n_checks++; if (hold_cnt !== 4'd1) begin n_fail++; $display("FAIL thr_late_high_hold: got %0d expected 1", hold_cnt); end
  endtask

  task automatic test_clr;
    window(10'd4, 14'd40);
    idle(1);
    send(10'd9, 5);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    n_checks++; if (conv !== 1'b0) begin n_fail++; $display("FAIL clr_conv: got %0b expected 0", conv); end
    n_checks++; if (hold_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_hold: got %0d expected 0", hold_cnt); end
    n_checks++; if (win_sum !== 14'd32) begin n_fail++; $display("FAIL clr_win_sum_kept: got %0d expected 32", win_sum); end
    n_checks++; if (dut.state_r !== 2'd0) begin n_fail++; $display("FAIL clr_state: got %0d expected 0", dut.state_r); end
    window(10'd2, 14'd40);
    n_checks++; if (win_sum !== 14'd16) begin n_fail++; $display("FAIL clr_next_sum: got %0d expected 16", win_sum); end
    idle(1);
    n_checks++; if (hold_cnt !== 4'd1) begin n_fail++; $display("FAIL clr_next_hold: got %0d expected 1", hold_cnt); end
    n_checks++; if (conv !== 1'b0) begin n_fail++; $display("FAIL clr_next_conv: got %0b expected 0", conv); end
    // clr during the evaluation cycle cancels that evaluation
    window(10'd2, 14'd40);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    n_checks++; if (hold_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_eval_hold: got %0d expected 0", hold_cnt); end
    n_checks++; if (win_done !== 1'b0) begin n_fail++; $display("FAIL clr_eval_done: got %0b expected 0", win_done); end
    n_checks++; if (win_sum !== 14'd16) begin n_fail++; $display("FAIL clr_eval_sum: got %0d expected 16", win_sum); end
  endtask

  task automatic test_reset_mid;
    window(10'd2, 14'd40);
    idle(1);
    send(10'd3, 5);
    #2;
    r = 1'b1;
    #1;
    n_checks++; if (win_sum !== 14'd0) begin n_fail++; $display("FAIL rmid_win_sum: got %0d expected 0", win_sum); end
    n_checks++; if (hold_cnt !== 4'd0) begin n_fail++; $display("FAIL rmid_hold: got %0d expected 0", hold_cnt); end
    n_checks++; if (conv !== 1'b0) begin n_fail++; $display("FAIL rmid_conv: got %0b expected 0", conv); end
    idle(1);
    r = 1'b0;
    window(10'd1, 14'd40);
    n_checks++; if (win_sum !== 14'd8) begin n_fail++; $display("FAIL rmid_next_sum: got %0d expected 8", win_sum); end
    n_checks++; if (win_done !== 1'b1) begin n_fail++; $display("FAIL rmid_next_done: got %0b expected 1", win_done); end
    idle(1);
    n_checks++; if (hold_cnt !== 4'd1) begin n_fail++; $display("FAIL rmid_next_hold: got %0d expected 1", hold_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_below_thr;
    test_above_thr;
    test_strict;
    test_back_to_back;
    test_thr_change;
    test_clr;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
